// File: rtl/fpga_cfg_loader.sv
// Byte-stream to serial CRAM chain loader for the fpga fabric.
// Optional CRC-16-CCITT trailer check enabled by defining CFG_CRC_EN.
module fpga_cfg_loader #(
    parameter  int CFG_BITS = 1024,
    localparam int CNT_W    = $clog2(CFG_BITS + 1)
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       config_en,
    output logic       config_data_out,
    input  logic       config_data_in,
    output logic       le_nrst_out,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       tail_bit
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd4;
`ifdef CFG_CRC_EN
    localparam logic [2:0] S_CRC   = 3'd3;
`endif

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       nb_q, nb_d;
    logic [7:0]       sreg_q, sreg_d;
    logic             tail_q;
    logic [16:0]      rem_w;
    logic             last_bit;
    logic             accept;
    logic             idle_or_done;

`ifdef CFG_CRC_EN
    logic [15:0] crc_q, crc_d;
    logic [15:0] crc_next;
    logic [7:0]  hi_q, hi_d;
    logic        hsel_q, hsel_d;
    logic        err_q, err_d;
`endif

    assign accept   = in_valid & in_ready;
    assign rem_w    = 17'(CFG_BITS) - 17'(cnt_q);
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign last_bit = (17'(cnt_inc) == 17'(CFG_BITS));

`ifdef CFG_CRC_EN
    // Bit-serial CCITT update using the bit currently on the chain input.
    assign crc_next = {crc_q[14:0], 1'b0}
                    ^ ((crc_q[15] ^ sreg_q[7]) ? 16'h1021 : 16'h0000);
`endif

    // Next-state logic for the load sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nb_d    = nb_q;
        sreg_d  = sreg_q;
`ifdef CFG_CRC_EN
        crc_d   = crc_q;
        hi_d    = hi_q;
        hsel_d  = hsel_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
`ifdef CFG_CRC_EN
                    crc_d   = 16'hFFFF;
                    hsel_d  = 1'b0;
                    err_d   = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                if (accept) begin
                    sreg_d  = in_data;
                    nb_d    = (rem_w >= 17'd8) ? 4'd8 : rem_w[3:0];
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                sreg_d = {sreg_q[6:0], 1'b0};
                cnt_d  = cnt_inc;
                nb_d   = nb_q - 4'd1;
`ifdef CFG_CRC_EN
                crc_d  = crc_next;
`endif
                if (nb_q == 4'd1) begin
`ifdef CFG_CRC_EN
                    state_d = last_bit ? S_CRC : S_LOAD;
`else
                    state_d = last_bit ? S_DONE : S_LOAD;
`endif
                end
            end
`ifdef CFG_CRC_EN
            S_CRC: begin
                if (accept) begin
                    if (!hsel_q) begin
                        hi_d   = in_data;
                        hsel_d = 1'b1;
                    end else begin
                        err_d   = ({hi_q, in_data} != crc_q);
                        state_d = S_DONE;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            nb_q    <= '0;
            sreg_q  <= '0;
`ifdef CFG_CRC_EN
            crc_q   <= 16'hFFFF;
            hi_q    <= '0;
            hsel_q  <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nb_q    <= nb_d;
            sreg_q  <= sreg_d;
`ifdef CFG_CRC_EN
            crc_q   <= crc_d;
            hi_q    <= hi_d;
            hsel_q  <= hsel_d;
            err_q   <= err_d;
`endif
        end
    end

    // Capture the chain tail every cycle for readback.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) tail_q <= 1'b0;
        else       tail_q <= config_data_in;
    end

    assign idle_or_done    = (state_q == S_IDLE) | (state_q == S_DONE);
    assign config_en       = (state_q == S_SHIFT);
    assign config_data_out = config_en & sreg_q[7];
    assign le_nrst_out     = idle_or_done;
    assign busy            = ~idle_or_done;
    assign done            = (state_q == S_DONE);
    assign tail_bit        = tail_q;
`ifdef CFG_CRC_EN
    assign in_ready = (state_q == S_LOAD) | (state_q == S_CRC);
    assign err      = err_q;
`else
    assign in_ready = (state_q == S_LOAD);
    assign err      = 1'b0;
`endif

endmodule

// File: doc/fpga_cfg_loader.md
# fpga_cfg_loader

Configuration loader sitting directly upstream of the `fpga` fabric's serial CRAM chain. Accepts the bitstream as a byte stream over a valid/ready handshake, shifts it MSB-first into the fabric's `config_data_in` with `config_en` gating each shift, and counts bits until the full chain length is loaded. Holds fabric logic in reset during loading and reports completion and error status to the host.

## Interface

Parameters:
- `CFG_BITS`, 1024: total CRAM chain length in bits, 1 to 65535.
- `CNT_W`, `$clog2(CFG_BITS+1)`: bit-counter width; derived, not overridden.

Ports:
- `clk`  in  1  single clock, shared with the fabric.
- `nrst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse; begins a load. Honoured in IDLE and DONE only.
- `in_data`  in  8  bitstream byte; first chain bit is `in_data[7]`.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `config_en`  out  1  to fabric `config_en`; high only on shift cycles.
- `config_data_out`  out  1  to fabric `config_data_in`.
- `config_data_in`  in  1  from fabric `config_data_out`; registered into `tail_bit` for debug.
- `le_nrst_out`  out  1  to fabric `le_nrst`; low from `start` until DONE.
- `busy`  out  1  high in LOAD, SHIFT, CRC.
- `done`  out  1  high in DONE.
- `err`  out  1  CRC mismatch flag; sticky until next `start`.
- `tail_bit`  out  1  `config_data_in` registered every cycle.

## Operation

- States: IDLE, LOAD, SHIFT, CRC (only with `CFG_CRC_EN`), DONE.
- IDLE: `in_ready`=0, `config_en`=0, `le_nrst_out`=1. `start` clears bit counter and `err`, goes to LOAD, drops `le_nrst_out`.
- LOAD: `in_ready`=1. On `in_valid && in_ready`, byte goes into an 8-bit shift register; `nbits` = min(8, CFG_BITS − count); go to SHIFT.
- SHIFT: `config_en`=1, `config_data_out`=`sreg[7]`, shift left each cycle, count+1. After `nbits` cycles: if count==CFG_BITS go to CRC/DONE, else LOAD. A final partial byte uses only its upper `nbits` bits.
- DONE: `done`=1, `le_nrst_out`=1. Holds until `start`, which restarts as from IDLE.
- `start` in LOAD/SHIFT/CRC is ignored. Bytes offered outside LOAD are not accepted (`in_ready`=0).
- Counter never exceeds CFG_BITS. No wrap.

## Timing

- Reset values: `in_ready`=0, `config_en`=0, `config_data_out`=0, `le_nrst_out`=1, `busy`=0, `done`=0, `err`=0, `tail_bit`=0; state IDLE.
- All outputs are registered or decoded from state/`sreg`, with no combinational path from inputs.
- `start` at edge N: LOAD from N+1, so `in_ready` is high in cycle N+1.
- Byte accepted at edge M: `config_en` high for cycles M+1 .. M+nbits, then one LOAD cycle (`config_en`=0) before the next byte. Minimum 9 cycles per full byte.
- Chain shifts only while `config_en`=1, so LOAD stalls and host back-pressure are safe.
- Last shift at edge L: DONE (`done`=1, `le_nrst_out`=1) from L+1 without CRC.
- `nrst` asserted mid-load: immediate return to reset values. The partially shifted chain is left as-is, and the host must reload.

## Configuration

- `CFG_CRC_EN` defined:
  - Every shifted bit updates a CRC-16-CCITT (poly 0x1021, init 0xFFFF, bit-serial, MSB-first).
  - After the last data bit, the CRC state accepts two more bytes: expected CRC high byte, then low byte. These are not shifted into the chain.
  - Mismatch sets `err`=1. DONE is entered either way, one cycle after the second byte is accepted.
- Not defined: no CRC logic, no CRC state, and `err` is tied to 0.

## Test plan

- CFG_BITS=20, bytes 0xA5, 0x3C, 0xF0 with `in_valid` always high -> `config_data_out` sequence 1010_0101_0011_1100_1111. `config_en` high exactly 20 cycles in runs of 8/8/4. `done`=1 on the cycle after the 20th shift.
- Same load, `in_valid` dropped for 5 cycles between bytes -> `config_en` stays 0 during the gap and the bit sequence is unchanged.
- Assert `nrst` after 10 shifted bits -> all outputs return to reset values next cycle. A restart with `start` loads 20 bits correctly.
- Pulse `start` mid-SHIFT -> ignored; count and sequence unaffected.
- With `CFG_CRC_EN`: send the bench-computed correct CRC -> `done`=1, `err`=0. Send the same CRC with bit 0 flipped -> `done`=1, `err`=1, and the flag clears on the next `start`.
- Full 4-cell `fpga` fabric behind the loader, CFG_BITS = chain length: load a pattern, then shift CFG_BITS zeros -> `tail_bit` reproduces the loaded pattern in order.
